// File: rtl/uart_rx_pkg.sv
// ============================================================================
// Module : uart_rx_pkg
// Brief  : Shared UART constants and the receiver state encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package uart_rx_pkg;

    // Oversampling factor shared with the transmitter; bit period = dvsr*OVRSMPL*2.
    localparam int unsigned OVRSMPL = 16;

    typedef enum logic [5:0] {
        IDLE      = 6'b000001,
        START     = 6'b000010,
        DATA      = 6'b000100,
        PARITY    = 6'b001000,
        STOP      = 6'b010000,
        WAIT_HIGH = 6'b100000
    } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// Module : uart_rx_sync
// Brief  : Two-flop synchroniser with a parameterised reset value.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module : uart_rx
// Brief  : UART receiver, 1 start, W_DATA data (LSB first), even parity, 1 stop.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int W_DATA = 8,
    parameter int W_DVSR = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_DVSR-1:0] dvsr,
    input  logic              rx_din,
    output logic [W_DATA-1:0] rx_dout,
    output logic              rx_done,
    output logic              parity_err,
    output logic              frame_err
);

    localparam int TW = W_DVSR + 6;
    localparam int BW = $clog2(W_DATA);

    rx_state_e         state_q, state_d;
    logic [W_DVSR-1:0] dvsr_q, dvsr_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [W_DATA-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic [W_DATA-1:0] rx_dout_q, rx_dout_d;
    logic              rx_done_q, rx_done_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              rx_prev_q;

    logic              rx_s;
    logic [TW-1:0]     w_half;
    logic [TW-1:0]     w_full;
    logic              w_fall;
    logic              w_start_ok;
    logic              w_half_end;
    logic              w_full_end;
    logic              w_last_bit;

    uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_din),
        .q   (rx_s)
    );

    assign w_half     = TW'(dvsr_q) * TW'(OVRSMPL);
    assign w_full     = w_half << 1;
    assign w_fall     = rx_prev_q & ~rx_s;
    assign w_start_ok = w_fall && (dvsr != '0);
    assign w_half_end = (tick_q == w_half - TW'(1));
    assign w_full_end = (tick_q == w_full - TW'(1));
    assign w_last_bit = (bit_q == BW'(W_DATA - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            dvsr_q    <= '0;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            rx_dout_q <= '0;
            rx_done_q <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            rx_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            dvsr_q    <= dvsr_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            rx_dout_q <= rx_dout_d;
            rx_done_q <= rx_done_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            rx_prev_q <= rx_s;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (w_start_ok) state_d = START;
            START:     if (w_half_end) state_d = rx_s ? IDLE : DATA;
            DATA:      if (w_full_end && w_last_bit) state_d = PARITY;
            PARITY:    if (w_full_end) state_d = STOP;
            STOP:      if (w_full_end) state_d = rx_s ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_s) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        dvsr_d    = dvsr_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_d     = par_q;
        rx_dout_d = rx_dout_q;
        rx_done_d = 1'b0;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        case (state_q)
            IDLE: begin
                if (w_start_ok) begin
                    dvsr_d  = dvsr;
                    tick_d  = '0;
                    bit_d   = '0;
                    shift_d = '0;
                end
            end
            START: begin
                tick_d = w_half_end ? '0 : tick_q + TW'(1);
            end
            DATA: begin
                if (w_full_end) begin
                    tick_d  = '0;
                    shift_d = {rx_s, shift_q[W_DATA-1:1]};
                    bit_d   = w_last_bit ? '0 : bit_q + BW'(1);
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            PARITY: begin
                if (w_full_end) begin
                    tick_d = '0;
                    par_d  = rx_s;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            STOP: begin
                // Results land one cycle after the mid-stop sample.
                if (w_full_end) begin
                    tick_d    = '0;
                    rx_dout_d = shift_q;
                    perr_d    = par_q ^ (^shift_q);
                    ferr_d    = ~rx_s;
                    rx_done_d = 1'b1;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            WAIT_HIGH: begin
                tick_d = '0;
            end
            default: begin
                tick_d = '0;
                bit_d  = '0;
            end
        endcase
    end

    assign rx_dout    = rx_dout_q;
    assign rx_done    = rx_done_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;

endmodule

`default_nettype wire
